roic_cfg_sequencer: RTL
=======================

Name: roic_cfg_sequencer

Overview:
Sequences ROIC gate-GPIO configuration over a shared byte-level I2C write engine. It expands one config request into a fixed four-write register program, with the required inter-write delay, NACK retry and a response timeout. It also arbitrates single register writes from the host/register bank onto the same engine. Sits between the ROIC control/register bank and the I2C write engine that drives scl_out/sda.

Parameters:
SLAVE_ADDR, 8'hE8, I2C slave address byte (0x74 7-bit, write bit 0).
DELAY_2MS, 50000, gap after each completed write in the program, in s_clk_25mhz cycles (2 ms); must be >= 1.
MAX_RETRY, 3, extra attempts allowed per write after a NACK or timeout.
TIMEOUT_CYC, 4000, cycles in WAIT without i2c_done before the attempt counts as a failed attempt.
DLY_W, 24, width of the delay/timeout counter; must hold max(DELAY_2MS, TIMEOUT_CYC).

Ports:
s_clk_25mhz  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: run the config program
gate_gpio_data  in  16  gate GPIO value, sampled when cfg_start is accepted
host_wr_req  in  1  level; host single-write request, held until host_wr_ack
host_wr_reg  in  8  host register index
host_wr_data  in  8  host data byte
host_wr_ack  out  1  one-cycle pulse on host request acceptance
host_wr_done  out  1  one-cycle pulse when host write ends; host_wr_err valid with it
host_wr_err  out  1  1 = host write failed after retries
i2c_req  out  1  request to I2C engine
i2c_slave_addr  out  8  address byte; stable while i2c_req=1
i2c_reg  out  8  register index byte; stable while i2c_req=1
i2c_data  out  8  data byte; stable while i2c_req=1
i2c_busy  in  1  engine transaction in progress
i2c_done  in  1  one-cycle pulse at transaction end
i2c_nack  in  1  valid with i2c_done; 1 = NACK received
seq_busy  out  1  config program active
seq_done  out  1  one-cycle pulse on program success
seq_error  out  1  sticky; program aborted; cleared when the next cfg_start is accepted
write_idx  out  2  index of the current program write (0-3)

Behaviour:
- Reset: async on rst_n low. All outputs 0, state IDLE, counters 0, snapshot 0.
- Program, fixed order: idx0 (0x06, 0x00); idx1 (0x02, snap[7:0]); idx2 (0x07, 0x00); idx3 (0x03, snap[15:8]). i2c_slave_addr is always SLAVE_ADDR.
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE:
  - cfg_start has priority over host_wr_req in the same cycle.
  - Accepting cfg_start: snap <= gate_gpio_data, seq_error <= 0, seq_busy <= 1, idx <= 0, retry <= 0, next state ISSUE.
  - Otherwise, if host_wr_req=1: pulse host_wr_ack, latch reg/data, mark the owner as host, next state ISSUE.
- ISSUE:
  - Drive i2c_req=1 with the selected bytes.
  - Hold until the first cycle i2c_busy=1 or i2c_done=1.
  - Then drop i2c_req (registered, next cycle), clear the timeout counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - i2c_done & !i2c_nack means success.
  - i2c_done & i2c_nack, or the counter reaching TIMEOUT_CYC, means a failed attempt.
- Success, owner = sequence: if idx = 3, pulse seq_done, go to DONE. Otherwise load DELAY_2MS, go to GAP; on exit, idx+1, retry <= 0.
- Success, owner = host: pulse host_wr_done with host_wr_err=0, go to DONE.
- Failed attempt with retry < MAX_RETRY: retry+1, load DELAY_2MS, go to GAP, then ISSUE with the same write.
- Failed attempt with retry = MAX_RETRY:
  - Sequence owner: set seq_error, no seq_done, go to DONE.
  - Host owner: host_wr_done=1 with host_wr_err=1.
- GAP: count down to 0, then go to ISSUE. Total gap is exactly DELAY_2MS cycles.
- DONE: clears seq_busy and the owner, then goes to IDLE one cycle later. Requests are served only from IDLE.
- cfg_start while seq_busy=1 or during a host write: ignored, no queueing.
- host_wr_req during a program: not acked; stays pending and is served in the first IDLE after DONE.
- gate_gpio_data changes after acceptance do not affect the running program.
- An i2c_done with no outstanding request (IDLE/GAP) is ignored.
- Counters saturate; there is no wrap. write_idx holds its last value when idle.

Test Plan:
- Nominal program: gate_gpio_data=16'hA55A, cfg_start pulse, engine ACKs everything. Required: writes (E8,06,00),(E8,02,5A),(E8,07,00),(E8,03,A5) in order; 50000-cycle gaps between them; one seq_done pulse; seq_error=0.
- NACK retry: NACK the first attempt of idx1. Required: idx1 reissued after 50000 cycles with the same bytes; the program then completes with seq_done.
- Abort: NACK idx2 four times. Required: four attempts on idx2; seq_error=1; no seq_done; no idx3 write; next cfg_start clears seq_error.
- Timeout: engine never asserts i2c_done. Required: each attempt ends after 4000 WAIT cycles, with 4 attempts total, then seq_error=1.
- Arbitration: cfg_start and host_wr_req (reg 0x10, data 0x33) asserted in the same cycle. Required: full program runs first, then host_wr_ack, then write (E8,10,33), then host_wr_done with err=0.
- Reset mid-operation: drop rst_n during WAIT of idx1. Required: all outputs 0 immediately; after release, no activity until a new cfg_start.

Source files
------------

// File: rtl/roic_cfg_sequencer.sv
// roic_cfg_sequencer: sequences the ROIC gate-GPIO configuration program and
// single host register writes onto a shared byte-level I2C write engine.
// Ports:
//   s_clk_25mhz, rst_n                     clock, async active-low reset
//   cfg_start, gate_gpio_data              start the 4-write config program
//   host_wr_req/reg/data, host_wr_ack/done/err   host single-write handshake
//   i2c_req/slave_addr/reg/data            request to the I2C write engine
//   i2c_busy/done/nack                     engine status
//   seq_busy, seq_done, seq_error, write_idx     program status
module roic_cfg_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR  = 8'hE8,
  parameter int unsigned DELAY_2MS   = 50000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 4000,
  parameter int unsigned DLY_W       = 24
) (
  input  logic        s_clk_25mhz,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [15:0] gate_gpio_data,
  input  logic        host_wr_req,
  input  logic [7:0]  host_wr_reg,
  input  logic [7:0]  host_wr_data,
  output logic        host_wr_ack,
  output logic        host_wr_done,
  output logic        host_wr_err,
  output logic        i2c_req,
  output logic [7:0]  i2c_slave_addr,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_data,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_error,
  output logic [1:0]  write_idx
);

  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               owner_host_q, owner_host_d;
  logic               adv_q, adv_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        snap_q, snap_d;
  logic               host_wr_ack_d, host_wr_done_d, host_wr_err_d;
  logic               i2c_req_d, seq_busy_d, seq_done_d, seq_error_d;
  logic [7:0]         i2c_slave_addr_d, i2c_reg_d, i2c_data_d;
  logic [1:0]         write_idx_d;
  logic [DLY_W-1:0]   cnt_inc;
  logic               ok, fail;

  // Register/data byte pair for each step of the fixed config program.
  function automatic logic [15:0] prog_bytes(input logic [1:0] idx, input logic [15:0] snap);
    case (idx)
      2'd0:    prog_bytes = {8'h06, 8'h00};
      2'd1:    prog_bytes = {8'h02, snap[7:0]};
      2'd2:    prog_bytes = {8'h07, 8'h00};
      default: prog_bytes = {8'h03, snap[15:8]};
    endcase
  endfunction

  // State and registered outputs.
  always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      owner_host_q   <= 1'b0;
      adv_q          <= 1'b0;
      retry_q        <= '0;
      cnt_q          <= '0;
      snap_q         <= '0;
      host_wr_ack    <= 1'b0;
      host_wr_done   <= 1'b0;
      host_wr_err    <= 1'b0;
      i2c_req        <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_reg        <= '0;
      i2c_data       <= '0;
      seq_busy       <= 1'b0;
      seq_done       <= 1'b0;
      seq_error      <= 1'b0;
      write_idx      <= '0;
    end else begin
      state_q        <= state_d;
      owner_host_q   <= owner_host_d;
      adv_q          <= adv_d;
      retry_q        <= retry_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      host_wr_ack    <= host_wr_ack_d;
      host_wr_done   <= host_wr_done_d;
      host_wr_err    <= host_wr_err_d;
      i2c_req        <= i2c_req_d;
      i2c_slave_addr <= i2c_slave_addr_d;
      i2c_reg        <= i2c_reg_d;
      i2c_data       <= i2c_data_d;
      seq_busy       <= seq_busy_d;
      seq_done       <= seq_done_d;
      seq_error      <= seq_error_d;
      write_idx      <= write_idx_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state_q;
    owner_host_d     = owner_host_q;
    adv_d            = adv_q;
    retry_d          = retry_q;
    cnt_d            = cnt_q;
    snap_d           = snap_q;
    host_wr_ack_d    = 1'b0;
    host_wr_done_d   = 1'b0;
    host_wr_err_d    = host_wr_err;
    i2c_req_d        = i2c_req;
    i2c_slave_addr_d = i2c_slave_addr;
    i2c_reg_d        = i2c_reg;
    i2c_data_d       = i2c_data;
    seq_busy_d       = seq_busy;
    seq_done_d       = 1'b0;
    seq_error_d      = seq_error;
    write_idx_d      = write_idx;
    cnt_inc          = (cnt_q == {DLY_W{1'b1}}) ? cnt_q : cnt_q + DLY_W'(1);
    ok               = i2c_done & ~i2c_nack;
    fail             = (i2c_done & i2c_nack) | (~i2c_done & (cnt_inc >= DLY_W'(TIMEOUT_CYC)));

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          snap_d                  = gate_gpio_data;
          seq_error_d             = 1'b0;
          seq_busy_d              = 1'b1;
          write_idx_d             = 2'd0;
          retry_d                 = '0;
          owner_host_d            = 1'b0;
          adv_d                   = 1'b0;
          i2c_req_d               = 1'b1;
          i2c_slave_addr_d        = SLAVE_ADDR;
          {i2c_reg_d, i2c_data_d} = prog_bytes(2'd0, gate_gpio_data);
          state_d                 = S_ISSUE;
        end else if (host_wr_req) begin
          host_wr_ack_d    = 1'b1;
          owner_host_d     = 1'b1;
          retry_d          = '0;
          adv_d            = 1'b0;
          i2c_req_d        = 1'b1;
          i2c_slave_addr_d = SLAVE_ADDR;
          i2c_reg_d        = host_wr_reg;
          i2c_data_d       = host_wr_data;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i2c_busy || i2c_done) begin
          i2c_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (ok) begin
          if (owner_host_q) begin
            host_wr_done_d = 1'b1;
            host_wr_err_d  = 1'b0;
            state_d        = S_DONE;
          end else if (write_idx == 2'd3) begin
            seq_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            cnt_d   = DLY_W'(DELAY_2MS);
            adv_d   = 1'b1;
            state_d = S_GAP;
          end
        end else if (fail) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            cnt_d   = DLY_W'(DELAY_2MS);
            adv_d   = 1'b0;
            state_d = S_GAP;
          end else if (owner_host_q) begin
            host_wr_done_d = 1'b1;
            host_wr_err_d  = 1'b1;
            state_d        = S_DONE;
          end else begin
            seq_error_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_GAP: begin
        // Leaving on cnt==1 makes the gap exactly DELAY_2MS cycles long.
        if (cnt_q <= DLY_W'(1)) begin
          cnt_d     = '0;
          i2c_req_d = 1'b1;
          state_d   = S_ISSUE;
          if (adv_q) begin
            write_idx_d             = write_idx + 2'd1;
            retry_d                 = '0;
            adv_d                   = 1'b0;
            {i2c_reg_d, i2c_data_d} = prog_bytes(write_idx + 2'd1, snap_q);
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      S_DONE: begin
        seq_busy_d   = 1'b0;
        owner_host_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
